// File: rtl/leer_rtc_registros.sv
// rtl/leer_rtc_registros.sv - reads NUM_REGS consecutive RTC registers over the multiplexed AD bus
module leer_rtc_registros #(
    parameter logic [7:0] BASE_ADDR = 8'h21,
    parameter int         NUM_REGS  = 6,
    parameter int         T_FASE    = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Inicie,
    input  logic [7:0] DatoBus_in,
    output logic [7:0] DireccionL,
    output logic       BusOE,
    output logic       ADL,
    output logic       RDL,
    output logic       WRL,
    output logic       CSL,
    output logic [7:0] DatoL,
    output logic [3:0] AddRegL,
    output logic       DatoValido,
    output logic       ReadyL
);

    localparam int         CW       = (T_FASE > 1) ? $clog2(T_FASE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(T_FASE - 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_STRB = 3'd1,
        A_HOLD = 3'd2,
        D_STRB = 3'd3,
        D_HOLD = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic          phase_end;

    logic [7:0] dir_d;
    logic       oe_d;
    logic       adl_d;
    logic       rdl_d;
    logic       wrl_d;
    logic       csl_d;
    logic [7:0] dato_d;
    logic [3:0] addreg_d;
    logic       valid_d;
    logic       ready_d;

    assign phase_end = (cnt == LAST_CNT);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE || state == DONE || next_state != state)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == IDLE && Inicie)
                idx <= '0;
            else if (state == D_HOLD && phase_end && idx != LAST_IDX)
                idx <= idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Inicie) next_state = A_STRB;
            A_STRB:  if (phase_end) next_state = A_HOLD;
            A_HOLD:  if (phase_end) next_state = D_STRB;
            D_STRB:  if (phase_end) next_state = D_HOLD;
            D_HOLD:  if (phase_end) next_state = (idx == LAST_IDX) ? DONE : A_STRB;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pins lag the state by one cycle, so the byte is taken on the first D_HOLD
    // cycle: that edge closes the last RDL-low cycle seen on the bus.
    always_comb begin
        dir_d    = DireccionL;
        oe_d     = 1'b0;
        adl_d    = 1'b1;
        rdl_d    = 1'b1;
        wrl_d    = 1'b1;
        csl_d    = 1'b1;
        addreg_d = AddRegL;
        valid_d  = 1'b0;
        ready_d  = 1'b0;
        case (state)
            A_STRB: begin
                csl_d    = 1'b0;
                adl_d    = 1'b0;
                wrl_d    = 1'b0;
                oe_d     = 1'b1;
                dir_d    = BASE_ADDR + {4'b0000, idx};
                addreg_d = idx;
            end
            A_HOLD: oe_d = 1'b1;
            D_STRB: begin
                csl_d = 1'b0;
                rdl_d = 1'b0;
            end
            D_HOLD:  valid_d = (cnt == '0);
            DONE:    ready_d = 1'b1;
            default: ;
        endcase
        dato_d = valid_d ? DatoBus_in : DatoL;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            DireccionL <= 8'h00;
            BusOE      <= 1'b0;
            ADL        <= 1'b1;
            RDL        <= 1'b1;
            WRL        <= 1'b1;
            CSL        <= 1'b1;
            DatoL      <= 8'h00;
            AddRegL    <= 4'h0;
            DatoValido <= 1'b0;
            ReadyL     <= 1'b0;
        end else begin
            DireccionL <= dir_d;
            BusOE      <= oe_d;
            ADL        <= adl_d;
            RDL        <= rdl_d;
            WRL        <= wrl_d;
            CSL        <= csl_d;
            DatoL      <= dato_d;
            AddRegL    <= addreg_d;
            DatoValido <= valid_d;
            ReadyL     <= ready_d;
        end
    end

endmodule
